// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and
// default counter geometry.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } state_e;

    localparam int DEF_W   = 16;
    localparam int DEF_MAX = 9999;

endpackage : stopwatch_pkg

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button rising-edge detector, used only when STOPWATCH_EDGE_DETECT_EN is defined.
// The button is registered twice; a press is seen one cycle after the
// button rises. The arm flag only sets once the button has been observed
// low after reset, so a button held through reset release is ignored.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic btn_q;
    logic btn_d;
    logic prev_q;
    logic prev_d;
    logic arm_q;
    logic arm_d;

    // Next values of the sampling pipeline and the arm flag.
    always_comb begin
        btn_d  = btn;
        prev_d = btn_q;
        arm_d  = arm_q | ~btn;
    end

    // Sampling registers, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q  <= 1'b0;
            prev_q <= 1'b0;
            arm_q  <= 1'b0;
        end else begin
            btn_q  <= btn_d;
            prev_q <= prev_d;
            arm_q  <= arm_d;
        end
    end

    assign press = btn_q & ~prev_q & arm_q;

endmodule : btn_edge

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/LAP/STOP state machine, wrapping tick
// counter and lap-freezable display register.
// Optional feature macro: STOPWATCH_EDGE_DETECT_EN (buttons are raw levels
// converted to single press events by btn_edge); without it the buttons
// are taken as pre-conditioned single-cycle pulses.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int MAX = DEF_MAX
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         start_btn,
    input  logic         lap_btn,
    input  logic         clr_btn,
    output logic         cnt_enable,
    output logic [W-1:0] count,
    output logic [W-1:0] disp,
    output logic         frozen,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO_V = {W{1'b0}};

    logic p_start_s;
    logic p_lap_s;
    logic p_clr_s;

`ifdef STOPWATCH_EDGE_DETECT_EN
    btn_edge u_start_edge (.clk(clk), .rst_n(rst_n), .btn(start_btn), .press(p_start_s));
    btn_edge u_lap_edge   (.clk(clk), .rst_n(rst_n), .btn(lap_btn),   .press(p_lap_s));
    btn_edge u_clr_edge   (.clk(clk), .rst_n(rst_n), .btn(clr_btn),   .press(p_clr_s));
`else
    assign p_start_s = start_btn;
    assign p_lap_s   = lap_btn;
    assign p_clr_s   = clr_btn;
`endif

    state_e       state_q;
    state_e       state_d;
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] disp_q;
    logic [W-1:0] disp_d;
    logic         wrap_q;
    logic         wrap_d;
    logic         counting_s;

    // Next-state logic; priority clr > start > lap among the events a state accepts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (p_start_s) state_d = RUN;
                else           state_d = IDLE;
            end
            RUN: begin
                if (p_start_s)    state_d = STOP;
                else if (p_lap_s) state_d = LAP;
                else              state_d = RUN;
            end
            LAP: begin
                if (p_start_s)    state_d = STOP;
                else if (p_lap_s) state_d = RUN;
                else              state_d = LAP;
            end
            STOP: begin
                if (p_clr_s)        state_d = IDLE;
                else if (p_start_s) state_d = RUN;
                else                state_d = STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter, wrap pulse and display; decisions use the current state so a
    // tick in a leaving-RUN/LAP cycle counts and a tick on entry does not.
    always_comb begin
        counting_s = (state_q == RUN) || (state_q == LAP);
        count_d    = count_q;
        wrap_d     = 1'b0;
        if ((state_q == STOP) && (state_d == IDLE)) begin
            count_d = ZERO_V;
        end else if (counting_s && en) begin
            if (count_q == MAX_V) begin
                count_d = ZERO_V;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + ONE_V;
            end
        end else begin
            count_d = count_q;
        end

        if ((state_q == LAP) && (state_d == LAP)) begin
            disp_d = disp_q;
        end else begin
            disp_d = count_d;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= ZERO_V;
            disp_q  <= ZERO_V;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            disp_q  <= disp_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cnt_enable = (state_q == RUN) || (state_q == LAP);
    assign frozen     = (state_q == LAP);
    assign count      = count_q;
    assign disp       = disp_q;
    assign wrap       = wrap_q;

endmodule : stopwatch_ctrl

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl. A second instance with
// MAX=9 shares the stimulus and is used for the wrap scenario.
module tb_stopwatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        start_btn = 1'b0;
    logic        lap_btn = 1'b0;
    logic        clr_btn = 1'b0;

    logic        cnt_enable;
    logic [15:0] count;
    logic [15:0] disp;
    logic        frozen;
    logic        wrap;

    logic        cnt_enable9;
    logic [15:0] count9;
    logic [15:0] disp9;
    logic        frozen9;
    logic        wrap9;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_ctrl #(.W(16), .MAX(9999)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .start_btn(start_btn), .lap_btn(lap_btn), .clr_btn(clr_btn),
        .cnt_enable(cnt_enable), .count(count), .disp(disp),
        .frozen(frozen), .wrap(wrap)
    );

    stopwatch_ctrl #(.W(16), .MAX(9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .start_btn(start_btn), .lap_btn(lap_btn), .clr_btn(clr_btn),
        .cnt_enable(cnt_enable9), .count(count9), .disp(disp9),
        .frozen(frozen9), .wrap(wrap9)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) tick();
        en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0;
        start_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // One button press; e is the tick strobe on the edge where the press acts.
    task automatic press(input logic s, input logic l, input logic c, input logic e);
`ifdef STOPWATCH_EDGE_DETECT_EN
        start_btn = s; lap_btn = l; clr_btn = c;
        tick();
        start_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0;
        en = e;
        tick();
        en = 1'b0;
`else
        start_btn = s; lap_btn = l; clr_btn = c; en = e;
        tick();
        start_btn = 1'b0; lap_btn = 1'b0; clr_btn = 1'b0; en = 1'b0;
`endif
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_disp", 32'(disp), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_cnt_en", 32'(cnt_enable), 32'd0);
        chk("rst_frozen", 32'(frozen), 32'd0);
        rst_n = 1'b1;
        tick();

        // Start; tick on the entry edge must not count
        press(1'b1, 1'b0, 1'b0, 1'b1);
        chk("start_cnt_en", 32'(cnt_enable), 32'd1);
        chk("start_entry_en", 32'(count), 32'd0);
        ticks(5);
        chk("run5_count", 32'(count), 32'd5);
        chk("run5_disp", 32'(disp), 32'd5);
        chk("run5_cnt_en", 32'(cnt_enable), 32'd1);

        // Lap freeze and release
        do_reset();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(3);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("lap_frozen", 32'(frozen), 32'd1);
        chk("lap_disp", 32'(disp), 32'd3);
        ticks(4);
        chk("lap_count", 32'(count), 32'd7);
        chk("lap_hold_disp", 32'(disp), 32'd3);
        chk("lap_cnt_en", 32'(cnt_enable), 32'd1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("unlap_disp", 32'(disp), 32'd7);
        chk("unlap_frozen", 32'(frozen), 32'd0);

        // clr ignored in RUN; stop with tick counted; clear from STOP
        press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("run_clr_cnt_en", 32'(cnt_enable), 32'd1);
        chk("run_clr_count", 32'(count), 32'd7);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        chk("stop_cnt_en", 32'(cnt_enable), 32'd0);
        chk("stop_exit_count", 32'(count), 32'd8);
        chk("stop_exit_disp", 32'(disp), 32'd8);
        ticks(2);
        chk("stop_hold_count", 32'(count), 32'd8);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        chk("stop_lap_ign", 32'(frozen), 32'd0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_disp", 32'(disp), 32'd0);
        chk("clr_cnt_en", 32'(cnt_enable), 32'd0);

        // Simultaneous events
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        chk("st_lap_cnt_en", 32'(cnt_enable), 32'd0);
        chk("st_lap_frozen", 32'(frozen), 32'd0);
        chk("st_lap_count", 32'(count), 32'd2);
        press(1'b1, 1'b0, 1'b1, 1'b0);
        chk("clr_st_cnt_en", 32'(cnt_enable), 32'd0);
        chk("clr_st_count", 32'(count), 32'd0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(4);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        chk("lap_clr_frozen", 32'(frozen), 32'd1);
        chk("lap_clr_disp", 32'(disp), 32'd4);
        ticks(2);
        chk("lap2_disp", 32'(disp), 32'd4);
        press(1'b1, 1'b1, 1'b0, 1'b1);
        chk("lapstop_cnt_en", 32'(cnt_enable), 32'd0);
        chk("lapstop_frozen", 32'(frozen), 32'd0);
        chk("lapstop_count", 32'(count), 32'd7);
        chk("lapstop_disp", 32'(disp), 32'd7);

        // Wrap at MAX=9
        do_reset();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(9);
        chk("pre_wrap_count", 32'(count9), 32'd9);
        chk("pre_wrap_wrap", 32'(wrap9), 32'd0);
        ticks(1);
        chk("wrap_count", 32'(count9), 32'd0);
        chk("wrap_pulse", 32'(wrap9), 32'd1);
        chk("wrap_disp", 32'(disp9), 32'd0);
        chk("nowrap_big", 32'(wrap), 32'd0);
        chk("big_count", 32'(count), 32'd10);
        tick();
        chk("wrap_one_cycle", 32'(wrap9), 32'd0);
        ticks(1);
        chk("post_wrap_count", 32'(count9), 32'd1);
        chk("post_wrap_wrap", 32'(wrap9), 32'd0);

        // Reset mid-count
        do_reset();
        press(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(42);
        chk("run42_count", 32'(count), 32'd42);
        rst_n = 1'b0; en = 1'b1; start_btn = 1'b1;
        tick();
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_disp", 32'(disp), 32'd0);
        chk("mrst_wrap", 32'(wrap), 32'd0);
        chk("mrst_cnt_en", 32'(cnt_enable), 32'd0);
        chk("mrst_frozen", 32'(frozen), 32'd0);
        start_btn = 1'b0; en = 1'b0; rst_n = 1'b1;
        tick();

`ifdef STOPWATCH_EDGE_DETECT_EN
        // Press latency of two edges
        do_reset();
        start_btn = 1'b1;
        tick();
        chk("edge_lat1", 32'(cnt_enable), 32'd0);
        tick();
        chk("edge_lat2", 32'(cnt_enable), 32'd1);
        // Held button: one event only
        for (int i = 0; i < 8; i++) tick();
        chk("held_once", 32'(cnt_enable), 32'd1);
        start_btn = 1'b0;
        tick(); tick();
        chk("held_release", 32'(cnt_enable), 32'd1);
        // Held across reset release: no event
        rst_n = 1'b0; start_btn = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("held_thru_rst", 32'(cnt_enable), 32'd0);
        start_btn = 1'b0;
        tick(); tick();
        chk("held_thru_rst_rel", 32'(cnt_enable), 32'd0);
`else
        // Level events act next edge and re-trigger while held
        do_reset();
        start_btn = 1'b1;
        tick();
        chk("lvl_next_edge", 32'(cnt_enable), 32'd1);
        tick();
        chk("lvl_retrig_stop", 32'(cnt_enable), 32'd0);
        tick();
        chk("lvl_retrig_run", 32'(cnt_enable), 32'd1);
        start_btn = 1'b0;
        tick();
        chk("lvl_release", 32'(cnt_enable), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_stopwatch_ctrl
